// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Command issue and result-capture stage in front of the 32-bit registered ALU.
//   Commands arrive over a valid/ready handshake and wait in a circular FIFO.
//   One command at a time is driven onto the ALU operand/select registers. The
//   ALU's registered result is captured two edges later and offered on a
//   valid/ready result port, tagged with its opcode.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   i_cmd_valid       command present
//   o_cmd_ready       command accepted when high (low in reset and when FIFO full)
//   i_cmd_a/b/op      operands and ALU select code (legal 0..8)
//   o_alu_a/b/sel     registered operands/select to the ALU
//   i_alu_y           ALU registered result
//   o_res_valid       result held
//   i_res_ready       consumer accepts result
//   o_res_data/op     captured result and the opcode that produced it
//   o_err_illegal     one-cycle pulse after an accepted illegal opcode
//   o_count           FIFO occupancy
module alu_issue_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [31:0]             i_cmd_a,
  input  logic [31:0]             i_cmd_b,
  input  logic [3:0]              i_cmd_op,
  output logic [31:0]             o_alu_a,
  output logic [31:0]             o_alu_b,
  output logic [3:0]              o_alu_sel,
  input  logic [31:0]             i_alu_y,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [31:0]             o_res_data,
  output logic [3:0]              o_res_op,
  output logic                    o_err_illegal,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StExec, StCapt} state_e;

  state_e        r_state;
  state_e        w_state_next;

  logic [31:0]   r_mem_a  [DEPTH];
  logic [31:0]   r_mem_b  [DEPTH];
  logic [3:0]    r_mem_op [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [31:0]   r_alu_a;
  logic [31:0]   r_alu_b;
  logic [3:0]    r_alu_sel;
  logic [3:0]    r_op_track;
  logic          r_res_valid;
  logic [31:0]   r_res_data;
  logic [3:0]    r_res_op;
  logic          r_err_illegal;

  logic          w_push;
  logic          w_legal;
  logic          w_enq;
  logic          w_pop;
  logic          w_capture;

  assign o_cmd_ready = !rst && (r_count != CW'(DEPTH));
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_legal     = (i_cmd_op <= 4'd8);
  // Illegal opcodes are consumed by the handshake but never stored.
  assign w_enq       = w_push && w_legal;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (r_count != '0) w_state_next = StExec;
      StExec: w_state_next = StCapt;
      StCapt: if (!r_res_valid || i_res_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: control strobes
  always_comb begin
    w_pop     = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      StIdle: w_pop = (r_count != '0);
      StExec: ;
      // Stalling here is safe: alu_* are held, so alu_y stays stable.
      StCapt: w_capture = !r_res_valid || i_res_ready;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_a[r_wr_ptr]  <= i_cmd_a;
      r_mem_b[r_wr_ptr]  <= i_cmd_b;
      r_mem_op[r_wr_ptr] <= i_cmd_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue and capture datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_sel     <= '0;
      r_op_track    <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_op      <= '0;
      r_err_illegal <= 1'b0;
    end else begin
      if (w_pop) begin
        r_alu_a    <= r_mem_a[r_rd_ptr];
        r_alu_b    <= r_mem_b[r_rd_ptr];
        r_alu_sel  <= r_mem_op[r_rd_ptr];
        r_op_track <= r_mem_op[r_rd_ptr];
      end
      // A capture on the same edge as a consume keeps valid high with new data.
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= i_alu_y;
        r_res_op    <= r_op_track;
      end else if (i_res_ready) begin
        r_res_valid <= 1'b0;
      end
      r_err_illegal <= w_push && !w_legal;
    end
  end

  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_sel     = r_alu_sel;
  assign o_res_valid   = r_res_valid;
  assign o_res_data    = r_res_data;
  assign o_res_op      = r_res_op;
  assign o_err_illegal = r_err_illegal;
  assign o_count       = r_count;

endmodule
